// File: rtl/sudoku_board_checker_pkg.sv
// Shared constants, FSM encoding and cell-index helper for the sudoku board checker.
package sudoku_pkg;
    localparam int GRID       = 9;
    localparam int CELL_W     = 4;
    localparam int BOARD_W    = GRID * GRID * CELL_W;
    localparam int NUM_GROUPS = 3 * GRID;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [6:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        return 7'(y) * 7'd9 + 7'(x);
    endfunction
endpackage

// File: rtl/sudoku_board_checker_if.sv
// Request/result bundle between the number-entry side and the board checker.
interface sudoku_board_checker_if;
    import sudoku_pkg::*;

    logic               start;
    logic [BOARD_W-1:0] array;
    logic               busy;
    logic               done;
    logic               valid;
    logic               complete;
    logic               solved;
    logic               conflict;
    logic [3:0]         conflict_x;
    logic [3:0]         conflict_y;

    modport master (
        output start, array,
        input  busy, done, valid, complete, solved, conflict, conflict_x, conflict_y
    );

    modport slave (
        input  start, array,
        output busy, done, valid, complete, solved, conflict, conflict_x, conflict_y
    );
endinterface

// File: rtl/sudoku_group_cell_map.sv
// Maps (group, element) to board coordinates: groups 0..8 rows, 9..17 columns, 18..26 boxes.
module sudoku_group_cell_map
    import sudoku_pkg::*;
(
    input  logic [4:0] i_g,
    input  logic [3:0] i_e,
    output logic [3:0] o_x,
    output logic [3:0] o_y
);
    logic [3:0] w_b;
    logic [3:0] w_bx;
    logic [3:0] w_by;

    always_comb begin
        w_b  = 4'(i_g - 5'(2 * GRID));
        w_bx = w_b % 4'd3;
        w_by = w_b / 4'd3;
        o_x  = '0;
        o_y  = '0;
        if (i_g < 5'(GRID)) begin
            o_x = i_e;
            o_y = i_g[3:0];
        end else if (i_g < 5'(2 * GRID)) begin
            o_x = 4'(i_g - 5'(GRID));
            o_y = i_e;
        end else begin
            o_x = w_bx * 4'd3 + i_e % 4'd3;
            o_y = w_by * 4'd3 + i_e / 4'd3;
        end
    end
endmodule

// File: rtl/sudoku_board_checker.sv
// Snapshots the board on start and walks all 27 groups one cell per clock,
// reporting duplicates, completeness and the first conflicting cell.
module sudoku_board_checker #(
    parameter int GRID   = 9,
    parameter int CELL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    sudoku_board_checker_if.slave bus
);
    import sudoku_pkg::state_e;
    import sudoku_pkg::ST_IDLE;
    import sudoku_pkg::ST_SCAN;
    import sudoku_pkg::ST_DONE;
    import sudoku_pkg::BOARD_W;
    import sudoku_pkg::NUM_GROUPS;
    import sudoku_pkg::cell_idx;

    state_e             r_state;
    state_e             w_next;
    logic [BOARD_W-1:0] r_snap;
    logic [4:0]         r_g;
    logic [3:0]         r_e;
    logic [8:0]         r_seen;
    logic               r_valid_w;
    logic               r_complete_w;
    logic               r_conflict_w;
    logic [3:0]         r_cx_w;
    logic [3:0]         r_cy_w;
    logic               r_done;
    logic               r_valid;
    logic               r_complete;
    logic               r_solved;
    logic               r_conflict;
    logic [3:0]         r_cx;
    logic [3:0]         r_cy;

    logic [3:0]         w_x;
    logic [3:0]         w_y;
    logic [6:0]         w_idx;
    logic [CELL_W-1:0]  w_v;
    logic [8:0]         w_onehot;
    logic               w_empty;
    logic               w_illegal;
    logic               w_dup;
    logic               w_flag;
    logic               w_last_e;
    logic               w_last;

    sudoku_group_cell_map u_map (
        .i_g (r_g),
        .i_e (r_e),
        .o_x (w_x),
        .o_y (w_y)
    );

    assign w_idx     = cell_idx(w_x, w_y);
    assign w_v       = r_snap[int'(w_idx) * CELL_W +: CELL_W];
    assign w_onehot  = 9'b1 << (w_v - CELL_W'(1));
    assign w_empty   = (w_v == '0);
    assign w_illegal = (w_v > CELL_W'(GRID));
    assign w_dup     = !w_empty && !w_illegal && |(r_seen & w_onehot);
    assign w_flag    = w_illegal | w_dup;
    assign w_last_e  = (r_e == 4'(GRID - 1));
    assign w_last    = w_last_e && (r_g == 5'(NUM_GROUPS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next = ST_SCAN;
            ST_SCAN: if (w_last)    w_next = ST_DONE;
            ST_DONE:                w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_snap       <= '0;
            r_g          <= '0;
            r_e          <= '0;
            r_seen       <= '0;
            r_valid_w    <= 1'b0;
            r_complete_w <= 1'b0;
            r_conflict_w <= 1'b0;
            r_cx_w       <= '0;
            r_cy_w       <= '0;
            r_done       <= 1'b0;
            r_valid      <= 1'b0;
            r_complete   <= 1'b0;
            r_solved     <= 1'b0;
            r_conflict   <= 1'b0;
            r_cx         <= '0;
            r_cy         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_snap       <= bus.array;
                        r_g          <= '0;
                        r_e          <= '0;
                        r_seen       <= '0;
                        r_valid_w    <= 1'b1;
                        r_complete_w <= 1'b1;
                        r_conflict_w <= 1'b0;
                        r_cx_w       <= '0;
                        r_cy_w       <= '0;
                    end
                end
                ST_SCAN: begin
                    if (w_empty) r_complete_w <= 1'b0;
                    if (w_flag) begin
                        r_valid_w <= 1'b0;
                        // Only the first conflict in group-then-element order is reported
                        if (!r_conflict_w) begin
                            r_conflict_w <= 1'b1;
                            r_cx_w       <= w_x;
                            r_cy_w       <= w_y;
                        end
                    end
                    if (w_last_e) begin
                        r_e    <= '0;
                        r_seen <= '0;
                        r_g    <= w_last ? 5'd0 : r_g + 5'd1;
                    end else begin
                        r_e <= r_e + 4'd1;
                        if (!w_empty && !w_illegal) r_seen <= r_seen | w_onehot;
                    end
                end
                ST_DONE: begin
                    r_done     <= 1'b1;
                    r_valid    <= r_valid_w;
                    r_complete <= r_complete_w;
                    r_solved   <= r_valid_w & r_complete_w;
                    r_conflict <= r_conflict_w;
                    r_cx       <= r_cx_w;
                    r_cy       <= r_cy_w;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.done       = r_done;
    assign bus.valid      = r_valid;
    assign bus.complete   = r_complete;
    assign bus.solved     = r_solved;
    assign bus.conflict   = r_conflict;
    assign bus.conflict_x = r_cx;
    assign bus.conflict_y = r_cy;
endmodule

// File: tb/tb_sudoku_board_checker.sv
// Scoreboard bench: each scan pushes its expected result and done cycle; the done monitor pops and compares.
module tb_sudoku_board_checker;
    import sudoku_pkg::*;

    typedef struct {
        logic [11:0] res;   // {valid, complete, solved, conflict, conflict_x, conflict_y}
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sudoku_board_checker_if bus();

    sudoku_board_checker #(.GRID(9), .CELL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    exp_t        e_item;
    logic [11:0] got;
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;

    int sol[81] = '{5,3,4,6,7,8,9,1,2,
                    6,7,2,1,9,5,3,4,8,
                    1,9,8,3,4,2,5,6,7,
                    8,5,9,7,6,1,4,2,3,
                    4,2,6,8,5,3,7,9,1,
                    7,1,3,9,2,4,8,5,6,
                    9,6,1,5,3,7,2,8,4,
                    2,8,7,4,1,9,6,3,5,
                    3,4,5,2,8,6,1,7,9};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            got = {bus.valid, bus.complete, bus.solved, bus.conflict, bus.conflict_x, bus.conflict_y};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done seen at cycle %0d, required no done", cyc);
            end else begin
                e_item = sb.pop_front();
                if (got !== e_item.res) begin
                    errors++;
                    $display("FAIL %s result: got %b required %b", e_item.name, got, e_item.res);
                end
                checks++;
                if (cyc !== e_item.cyc) begin
                    errors++;
                    $display("FAIL %s done_cycle: got %0d required %0d", e_item.name, cyc, e_item.cyc);
                end
            end
        end
    end

    function automatic logic [BOARD_W-1:0] set_cell(input logic [BOARD_W-1:0] b, input int x,
                                                     input int y, input logic [3:0] v);
        b[4 * (y * 9 + x) +: 4] = v;
        return b;
    endfunction

    function automatic logic [BOARD_W-1:0] solved_board();
        logic [BOARD_W-1:0] b = '0;
        for (int i = 0; i < 81; i++) b[4 * i +: 4] = 4'(sol[i]);
        return b;
    endfunction

    task automatic kick(input logic [BOARD_W-1:0] b, input logic [11:0] res, input string name);
        @(negedge clk);
        bus.array = b;
        bus.start = 1'b1;
        sb.push_back('{res, cyc + 245, name});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 600 && done_cnt < target; i++) @(negedge clk);
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL %s timeout: done count %0d required %0d", name, done_cnt, target);
        end
    endtask

    task automatic test_reset();
        logic [13:0] outs;
        bus.start = 1'b0;
        bus.array = '0;
        #2 rst = 1'b0;
        #1;
        outs = {bus.busy, bus.done, bus.valid, bus.complete, bus.solved, bus.conflict,
                bus.conflict_x, bus.conflict_y};
        checks++;
        if (outs !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0", outs);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b required 0", bus.busy);
        end
    endtask

    task automatic test_all_zero();
        kick('0, {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}, "all_zero");
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL scan_busy: got %b required 1", bus.busy);
        end
        wait_done(done_cnt + 1, "all_zero");
    endtask

    task automatic test_solved();
        kick(solved_board(), {1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0}, "solved");
        wait_done(done_cnt + 1, "solved");
    endtask

    task automatic test_row_dup();
        logic [BOARD_W-1:0] b = set_cell(set_cell('0, 0, 0, 4'd5), 3, 0, 4'd5);
        kick(b, {1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0}, "row_dup");
        wait_done(done_cnt + 1, "row_dup");
    endtask

    task automatic test_box_dup();
        logic [BOARD_W-1:0] b = set_cell(set_cell('0, 0, 0, 4'd1), 1, 1, 4'd1);
        kick(b, {1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1}, "box_dup");
        wait_done(done_cnt + 1, "box_dup");
    endtask

    task automatic test_illegal();
        kick(set_cell('0, 4, 4, 4'hA), {1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 4'd4}, "illegal");
        wait_done(done_cnt + 1, "illegal");
    endtask

    task automatic test_incomplete();
        kick(set_cell(solved_board(), 8, 8, 4'd0), {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}, "incomplete");
        wait_done(done_cnt + 1, "incomplete");
    endtask

    task automatic test_isolation();
        int base = done_cnt;
        kick('0, {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0}, "isolation");
        repeat (50) @(negedge clk);
        bus.array = set_cell(set_cell('0, 0, 0, 4'd5), 3, 0, 4'd5);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(base + 1, "isolation");
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt !== base + 1) begin
            errors++;
            $display("FAIL mid_start_retrigger: done count %0d required %0d", done_cnt, base + 1);
        end
    endtask

    task automatic test_back_to_back();
        int base = done_cnt;
        @(negedge clk);
        bus.array = set_cell(set_cell('0, 0, 0, 4'd5), 3, 0, 4'd5);
        bus.start = 1'b1;
        sb.push_back('{{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0}, cyc + 245, "held_first"});
        sb.push_back('{{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0}, cyc + 490, "held_second"});
        wait_done(base + 1, "held_first");
        repeat (5) @(negedge clk);
        bus.start = 1'b0;
        wait_done(base + 2, "held_second");
    endtask

    task automatic test_reset_mid_scan();
        logic [13:0] outs;
        int base = done_cnt;
        kick(solved_board(), {1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0}, "aborted");
        repeat (99) @(negedge clk);
        rst = 1'b0;
        #1;
        sb.delete();
        outs = {bus.busy, bus.done, bus.valid, bus.complete, bus.solved, bus.conflict,
                bus.conflict_x, bus.conflict_y};
        checks++;
        if (outs !== 14'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b required 0", outs);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (done_cnt !== base || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_no_done: done count %0d busy %b required %0d busy 0",
                     done_cnt, bus.busy, base);
        end
    endtask

    task automatic test_restart();
        kick(solved_board(), {1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0}, "restart");
        wait_done(done_cnt + 1, "restart");
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_solved();
        test_row_dup();
        test_box_dup();
        test_illegal();
        test_incomplete();
        test_isolation();
        test_back_to_back();
        test_reset_mid_scan();
        test_restart();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sudoku_board_checker.md
Name: sudoku_board_checker

Overview:
- Reader/validator for the 324-bit sudoku board written by the number-entry logic: 81 cells × 4 bits, cell i at bits [4i+3:4i], i = y*9 + x.
- On `start`, snapshots the board and sequentially scans all 27 groups (9 rows, 9 columns, 9 boxes), one cell per clock.
- Reports whether the board has duplicates, whether it is fully filled, and the coordinates of the first conflict.
- Results feed the game-status / display logic.

Parameters:
- GRID, 9, side length of the board; only 9 is supported.
- CELL_W, 4, bits per cell.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a scan; sampled only in IDLE.
- array  input  324  board; cell i = array[4i+3:4i]; 0 = empty, 1..9 = digit.
- busy  output  1  high while in SCAN or DONE.
- done  output  1  one-cycle pulse when results are updated.
- valid  output  1  no duplicates and no illegal values among non-empty cells.
- complete  output  1  no cell equals 0.
- solved  output  1  valid & complete.
- conflict  output  1  at least one conflict found.
- conflict_x  output  4  x (0..8) of the first conflicting cell.
- conflict_y  output  4  y (0..8) of the first conflicting cell.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - All outputs and internal registers are 0, including valid.
  - Reset mid-scan aborts the scan; no done pulse is produced.
- States: IDLE, SCAN, DONE.
  - IDLE → SCAN when start = 1. On that edge:
    - Capture array into the snapshot register.
    - Clear g = 0, e = 0, seen = 0.
    - Set the working flags to valid_w = 1, complete_w = 1, conflict_w = 0.
  - SCAN: one cell per cycle, group g (0..26), element e (0..8).
    - e wraps 8 → 0 with g+1, and seen clears at the wrap.
    - After g = 26, e = 8 → DONE.
  - DONE (one cycle):
    - Copy the working flags to valid/complete/conflict/conflict_x/conflict_y.
    - solved = valid_w & complete_w.
    - done = 1.
    - Next state is IDLE.
- Group → cell map:
  - g 0..8 (row): y = g, x = e.
  - g 9..17 (column): x = g−9, y = e.
  - g 18..26 (box b = g−18): y = 3*(b/3) + e/3, x = 3*(b%3) + e%3.
- Per-cell rule, with v = snapshot cell:
  - v = 0: complete_w ← 0.
  - v in 1..9: if seen[v−1] is set, flag a conflict; otherwise set seen[v−1].
  - v in 10..15: flag a conflict (illegal value).
  - Conflict flag: valid_w ← 0. If conflict_w = 0, latch x/y of the current cell and set conflict_w (first conflict only, in g-then-e order).
  - Empty cells in rows are counted each time they are visited; complete_w is a sticky clear.
- Latency:
  - start high at edge 0 → SCAN for edges 1..243 (243 cells) → done high during the cycle after edge 244.
  - Outputs hold until the next done or reset.
- Board isolation: changes on `array` during a scan do not affect the result (snapshot).
- start while busy is ignored; no queuing.
- start held continuously re-triggers on each return to IDLE (one IDLE cycle between scans).
- Arithmetic: g is 5 bits, e is 4 bits, seen is 9 bits; no counter exceeds its range.

Decomposition:
- Package sudoku_pkg:
  - GRID = 9, CELL_W = 4, BOARD_W = 324, NUM_GROUPS = 27.
  - State encoding IDLE/SCAN/DONE.
  - Helper for cell index = y*9 + x.
- Sub-module sudoku_group_cell_map:
  - Combinational (g, e) → (x, y).
  - Reused by the display/highlight logic.
- Checker holds: FSM, counters, seen mask, snapshot, result registers.

Test Plan:
- All-zero board, start → done after 244 cycles; valid = 1, complete = 0, solved = 0, conflict = 0.
- Known fully solved grid (row 0 = 5,3,4,6,7,8,9,1,2 …) → valid = 1, complete = 1, solved = 1, conflict = 0.
- Empty board with (0,0) = 5 and (3,0) = 5 → valid = 0, conflict = 1, conflict_x = 3, conflict_y = 0 (detected in group 0, element 3).
- Empty board with (0,0) = 1 and (1,1) = 1 (box-only duplicate) → conflict = 1, conflict_x = 1, conflict_y = 1 (group 18, element 4).
- Cell (4,4) = 4'hA, rest empty → valid = 0, conflict_x = 4, conflict_y = 4.
- Reset and re-trigger:
  - rst low at cycle 100 of a scan → busy = 0, all outputs 0, no done.
  - Restart → normal done at +244.
  - A second start pulse mid-scan does not change the done timing.
